// File: rtl/writeback_stage.sv
// Writeback stage: 2-entry FIFO between MEM and the register-file write port, with load formatting and a retire counter.
// Optional build macro WB_FORWARD_EN adds fwd_valid/fwd_reg/fwd_data (youngest buffered register write).
package writeback_stage_pkg;
  typedef struct packed {
    logic [4:0]  rd;
    logic        we;
    logic [31:0] data;
  } wb_entry_t;
endpackage

module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_rd,
  input  logic             in_reg_write,
  input  logic [1:0]       in_wb_sel,
  input  logic [2:0]       in_funct3,
  input  logic [31:0]      in_alu_result,
  input  logic [31:0]      in_load_data,
  input  logic [31:0]      in_pc_plus4,
  input  logic             flush,
  input  logic             wb_stall,
`ifdef WB_FORWARD_EN
  output logic             fwd_valid,
  output logic [4:0]       fwd_reg,
  output logic [31:0]      fwd_data,
`endif
  output logic             reg_write,
  output logic [4:0]       write_reg,
  output logic [31:0]      write_data,
  output logic [CNT_W-1:0] retire_count
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned RD_W = 5;

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]      state, state_nxt;
  logic            push, pop;
  wb_entry_t       head, tail, new_entry;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_value;

  // Load formatting: byte/halfword lane select then sign/zero extension
  always_comb begin
    ld_byte = 8'h00;
    case (in_alu_result[1:0])
      2'd0:    ld_byte = in_load_data[7:0];
      2'd1:    ld_byte = in_load_data[15:8];
      2'd2:    ld_byte = in_load_data[23:16];
      default: ld_byte = in_load_data[31:24];
    endcase
    ld_half = in_alu_result[1] ? in_load_data[31:16] : in_load_data[15:0];
    case (in_funct3)
      3'b000:  ld_value = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_value = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_value = {24'h000000, ld_byte};
      3'b101:  ld_value = {16'h0000, ld_half};
      default: ld_value = in_load_data;
    endcase
  end

  always_comb begin
    new_entry.rd = in_rd;
    new_entry.we = in_reg_write;
    case (in_wb_sel)
      2'd1:    new_entry.data = ld_value;
      2'd2:    new_entry.data = in_pc_plus4;
      default: new_entry.data = in_alu_result;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= EMPTY;
    else       state <= state_nxt;
  end

  // Occupancy next-state and handshake; flush overrides both push and pop
  always_comb begin
    state_nxt = state;
    push      = in_valid && (state != FULL) && !flush;
    pop       = (state != EMPTY) && !wb_stall && !flush;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY:   if (push) state_nxt = ONE;
        ONE: begin
          if (pop && !push)      state_nxt = EMPTY;
          else if (push && !pop) state_nxt = FULL;
        end
        FULL:    if (pop) state_nxt = ONE;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Head is always slot 'head'; popping from FULL shifts the tail forward
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
    end else begin
      case (state)
        EMPTY: if (push) head <= new_entry;
        ONE: begin
          if (push && pop) head <= new_entry;
          else if (push)   tail <= new_entry;
        end
        FULL:    if (pop) head <= tail;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)    retire_count <= '0;
    else if (pop) retire_count <= retire_count + CNT_W'(1);
  end

  always_comb begin
    in_ready   = (state != FULL);
    reg_write  = pop && head.we && (head.rd != RD_W'(0));
    write_reg  = (state != EMPTY) ? head.rd : RD_W'(0);
    write_data = (state != EMPTY) ? head.data : XLEN'(0);
  end

`ifdef WB_FORWARD_EN
  // Youngest qualifying entry wins: tail when FULL, otherwise head
  always_comb begin
    fwd_valid = 1'b0;
    fwd_reg   = RD_W'(0);
    fwd_data  = XLEN'(0);
    if (!flush) begin
      if (state == FULL && tail.we && tail.rd != RD_W'(0)) begin
        fwd_valid = 1'b1;
        fwd_reg   = tail.rd;
        fwd_data  = tail.data;
      end else if (state != EMPTY && head.we && head.rd != RD_W'(0)) begin
        fwd_valid = 1'b1;
        fwd_reg   = head.rd;
        fwd_data  = head.data;
      end
    end
  end
`endif

endmodule
